// File: rtl/rr_arb32_pkg.sv
// Shared types and constants for the 32-way round-robin arbiter.
// Holds the FSM encoding, requester count and a one-hot decode helper.
package rr_arb32_pkg;

   localparam int NREQ  = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] dec_oh(input logic [IDX_W-1:0] idx);
      dec_oh      = '0;
      dec_oh[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/MUX32to1.sv
// Shared 32-to-1 bit multiplexer.
// The arbiter owns its index input.
module MUX32to1 (
   input  logic [31:0] set,
   input  logic [4:0]  idx,
   output logic        out
);

   assign out = set[idx];

endmodule

// File: rtl/rr_penc32.sv
// Rotating priority encoder: first set bit at or after start, wrapping.
// Masked encode of bits >= start, falling back to a plain encode.
module rr_penc32
   import rr_arb32_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [NREQ-1:0]  mask;
   logic [NREQ-1:0]  hi;
   logic [IDX_W-1:0] idx_hi;
   logic [IDX_W-1:0] idx_lo;

   always_comb begin
      mask   = {NREQ{1'b1}} << start;
      hi     = req & mask;
      idx_hi = '0;
      idx_lo = '0;
      // descending scan so the lowest set bit is the one that sticks
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (hi[i])  idx_hi = IDX_W'(i);
         if (req[i]) idx_lo = IDX_W'(i);
      end
      idx   = (|hi) ? idx_hi : idx_lo;
      found = |req;
   end

endmodule

// File: rtl/rr_arb32.sv
// Round-robin arbiter driving the shared MUX32to1 select.
// Rotating pointer for fairness, optional hold timeout per grant.
module rr_arb32
   import rr_arb32_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] req,
   input  logic        rel,
   input  logic [31:0] dat,
   output logic        gnt_vld,
   output logic [4:0]  gnt_idx,
   output logic [31:0] gnt_oh,
   output logic        gnt_bit,
   output logic        revoked
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   state_t           state_nx;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [IDX_W-1:0] idx_nx;
   logic             rev_nx;

   logic             end_rel;
   logic             end_drop;
   logic             end_to;
   logic             fin;
   logic [NREQ-1:0]  rest;
   logic [IDX_W-1:0] nxt_base;
   logic [IDX_W-1:0] pe_start;
   logic [IDX_W-1:0] pe_idx;
   logic             pe_found;
   logic             mux_out;

   // gnt_oh is zero in IDLE, so one encoder serves both states
   assign nxt_base = gnt_idx + 5'd1;
   assign rest     = req & ~gnt_oh;
   assign pe_start = (state == ST_BUSY) ? nxt_base : ptr;

   rr_penc32 u_penc (
      .req   (rest),
      .start (pe_start),
      .idx   (pe_idx),
      .found (pe_found)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         gnt_idx <= '0;
         gnt_oh  <= '0;
         ptr     <= '0;
         cnt     <= '0;
         revoked <= 1'b0;
      end else begin
         state   <= state_nx;
         gnt_idx <= idx_nx;
         gnt_oh  <= (state_nx == ST_BUSY) ? dec_oh(idx_nx) : '0;
         ptr     <= ptr_nx;
         cnt     <= cnt_nx;
         revoked <= rev_nx;
      end
   end

   always_comb begin
      end_rel  = rel;
      end_drop = ~req[gnt_idx];
      end_to   = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
      fin      = (state == ST_BUSY) && (end_rel || end_drop || end_to);
      state_nx = state;
      unique case (state)
         ST_IDLE: if (pe_found) state_nx = ST_BUSY;
         ST_BUSY: if (fin && !pe_found) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      idx_nx = gnt_idx;
      ptr_nx = ptr;
      cnt_nx = cnt;
      rev_nx = 1'b0;
      if (state == ST_IDLE) begin
         if (pe_found) begin
            idx_nx = pe_idx;
            cnt_nx = '0;
         end
      end else if (fin) begin
         // rel wins over drop/timeout: a normal release never pulses revoked
         ptr_nx = nxt_base;
         rev_nx = ~end_rel;
         if (pe_found) begin
            idx_nx = pe_idx;
            cnt_nx = '0;
         end
      end else if (cnt != CNT_MAX) begin
         cnt_nx = cnt + 1'b1;
      end
   end

   MUX32to1 u_mux (
      .set (dat),
      .idx (gnt_idx),
      .out (mux_out)
   );

   assign gnt_vld = (state == ST_BUSY);
   assign gnt_bit = mux_out & gnt_vld;

endmodule

// File: tb/tb_rr_arb32.sv
// Bench for rr_arb32: directed scenarios then random traffic,
// all checked against a behavioural round-robin model.
module tb_rr_arb32;

   localparam int MAX_HOLD = 16;
   localparam int CNT_MAX  = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] req;
   logic        rel;
   logic [31:0] dat;
   logic        gnt_vld;
   logic [4:0]  gnt_idx;
   logic [31:0] gnt_oh;
   logic        gnt_bit;
   logic        revoked;

   int total = 0;
   int bad   = 0;

   bit m_busy;
   int m_idx;
   int m_ptr;
   int m_cnt;
   bit m_rev;

   rr_arb32 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .rel     (rel),
      .dat     (dat),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .gnt_oh  (gnt_oh),
      .gnt_bit (gnt_bit),
      .revoked (revoked)
   );

   always #5 clk = ~clk;

   function automatic int sel(input logic [31:0] r, input int p);
      for (int k = 0; k < 32; k++) begin
         if (r[(p + k) % 32]) return (p + k) % 32;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [31:0] others;
      bit fin;
      if (!rst_n) begin
         m_busy = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_rev = 0;
      end else if (!m_busy) begin
         m_rev = 0;
         if (req != 0) begin
            m_busy = 1;
            m_idx  = sel(req, m_ptr);
            m_cnt  = 0;
         end
      end else begin
         fin = rel || !req[m_idx] || (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1);
         if (fin) begin
            m_ptr  = (m_idx + 1) % 32;
            m_rev  = !rel;
            others = req;
            others[m_idx] = 1'b0;
            if (others != 0) begin
               m_idx = sel(others, m_ptr);
               m_cnt = 0;
            end else begin
               m_busy = 0;
            end
         end else begin
            m_rev = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
      end
   endtask

   task automatic cmp_all(input string tag);
      logic [31:0] oh;
      oh = m_busy ? (32'd1 << m_idx) : 32'd0;
      chk({tag, ".vld"}, 32'(gnt_vld), 32'(m_busy));
      if (m_busy) chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
      chk({tag, ".oh"}, gnt_oh, oh);
      chk({tag, ".rev"}, 32'(revoked), 32'(m_rev));
      chk({tag, ".bit"}, 32'(gnt_bit), m_busy ? 32'(dat[m_idx]) : 32'd0);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      cmp_all(tag);
   endtask

   initial begin
      int vcnt;
      rst_n = 1'b0; req = '0; rel = 1'b0; dat = '0;
      #1;
      tick("rst");
      chk("rst.idx", 32'(gnt_idx), 32'd0);
      chk("rst.oh", gnt_oh, 32'd0);

      rst_n = 1'b1; req = 32'h0000_0011;
      tick("t1a");
      chk("t1.first", 32'(gnt_idx), 32'd0);
      rel = 1'b1;
      tick("t1b");
      chk("t1.regrant", 32'(gnt_idx), 32'd4);
      chk("t1.nobubble", 32'(gnt_vld), 32'd1);
      req = 32'h0000_0010;
      tick("t1c");
      chk("t1.idle", 32'(gnt_vld), 32'd0);
      req = '0; rel = 1'b0;
      tick("t1d");

      req = 32'h8000_0001;
      tick("t2a");
      chk("t2.g0", 32'(gnt_idx), 32'd31);
      rel = 1'b1;
      tick("t2b");
      chk("t2.g1", 32'(gnt_idx), 32'd0);
      tick("t2c");
      chk("t2.g2", 32'(gnt_idx), 32'd31);
      tick("t2d");
      chk("t2.g3", 32'(gnt_idx), 32'd0);
      req = '0;
      tick("t2e");
      rel = 1'b0;

      req = 32'h0000_0004;
      vcnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick("t3hold");
         if (gnt_vld) vcnt++;
      end
      chk("t3.vldcycles", 32'(vcnt), 32'd16);
      tick("t3rev");
      chk("t3.revoked", 32'(revoked), 32'd1);
      chk("t3.gap", 32'(gnt_vld), 32'd0);
      tick("t3re");
      chk("t3.regrant", 32'(gnt_idx), 32'd2);
      chk("t3.revone", 32'(revoked), 32'd0);
      req = '0; rel = 1'b1;
      tick("t3end");
      rel = 1'b0;

      req = 32'h0000_0280;
      tick("t4a");
      chk("t4.g7", 32'(gnt_idx), 32'd7);
      req = 32'h0000_0200; dat = 32'h0000_0200;
      tick("t4b");
      chk("t4.drop", 32'(revoked), 32'd1);
      chk("t4.g9", 32'(gnt_idx), 32'd9);
      chk("t4.bit1", 32'(gnt_bit), 32'd1);
      dat = 32'h0;
      #1;
      chk("t4.bit0", 32'(gnt_bit), 32'd0);
      req = '0; rel = 1'b1;
      tick("t4end");
      rel = 1'b0;

      req = 32'h0000_0008;
      for (int i = 0; i < 16; i++) tick("t5hold");
      rel = 1'b1;
      tick("t5relto");
      chk("t5.norev", 32'(revoked), 32'd0);
      chk("t5.idle", 32'(gnt_vld), 32'd0);
      rel = 1'b0; req = 32'h0000_0028;
      tick("t5ptr");
      chk("t5.ptradv", 32'(gnt_idx), 32'd5);
      req = '0; rel = 1'b1;
      tick("t5drop");
      tick("t5idlerel");
      chk("t5.idlerel", 32'(gnt_vld), 32'd0);
      req = 32'h0000_0060; rel = 1'b0;
      tick("t5b");
      chk("t5.ptrkeep", 32'(gnt_idx), 32'd6);

      req = 32'h0000_1000; rel = 1'b1;
      tick("t6a");
      chk("t6.g12", 32'(gnt_idx), 32'd12);
      rst_n = 1'b0; rel = 1'b0;
      tick("t6rst");
      chk("t6.vld", 32'(gnt_vld), 32'd0);
      chk("t6.idx", 32'(gnt_idx), 32'd0);
      chk("t6.rev", 32'(revoked), 32'd0);
      rst_n = 1'b1; req = 32'h8000_0002;
      tick("t6b");
      chk("t6.ptr0", 32'(gnt_idx), 32'd1);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 2) == 0) req = 32'd1 << $urandom_range(0, 31);
            else req = $urandom & $urandom & $urandom;
         end
         rel   = ($urandom_range(0, 9) == 0);
         dat   = $urandom;
         rst_n = ($urandom_range(0, 499) != 0);
         tick("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
